// File: rtl/frame_tx_sched.sv
// frame_tx_sched: round-robin arbiter that serializes one granted payload per frame
// as header, four data bytes and a byte-sum checksum, MSB first.
module frame_tx_sched #(
    parameter int NREQ = 4,
    parameter int HEAD_W = 8,
    parameter logic [HEAD_W-1:0] HEAD_PAT = HEAD_W'(8'hA5),
    parameter int GAP_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              tx_data,
    output logic              tx_en,
    output logic              busy,
    output logic              done
);
    localparam int SW = HEAD_W + 40;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HP = (HEAD_W > 40) ? HEAD_W : 40;
    localparam int CMX = (HP > GAP_CYC) ? HP : GAP_CYC;
    localparam int CW = $clog2(CMX);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            tx_data_q, tx_data_d, tx_en_q, tx_en_d, busy_q, busy_d, done_q, done_d;
    logic [PW-1:0]   win, idx;
    logic            found, grant;
    logic [31:0]     wd;
    logic [7:0]      csum;

    // Search starts just after the last winner, so the previous winner ranks last.
    always_comb begin
        win = rr_q;
        idx = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(rr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
        wd = req_data[32*int'(win) +: 32];
        csum = wd[31:24] + wd[23:16] + wd[15:8] + wd[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            rr_q      <= PW'(NREQ - 1);
            gnt_q     <= '0;
            tx_data_q <= 1'b0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Header and payload share one shift register; its MSB is the next bit on the wire.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sr_d = sr_q;
        rr_d = rr_q;
        grant = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                state_d = HEAD;
                cnt_d = '0;
                sr_d = {HEAD_PAT, wd, csum};
                rr_d = win;
                grant = 1'b1;
            end
            HEAD: begin
                sr_d = sr_q << 1;
                state_d = (cnt_q == CW'(HEAD_W - 1)) ? PAYLOAD : HEAD;
                cnt_d = (cnt_q == CW'(HEAD_W - 1)) ? '0 : cnt_q + CW'(1);
            end
            PAYLOAD: begin
                sr_d = sr_q << 1;
                state_d = (cnt_q == CW'(39)) ? GAP : PAYLOAD;
                cnt_d = (cnt_q == CW'(39)) ? '0 : cnt_q + CW'(1);
            end
            default: begin
                state_d = (cnt_q == CW'(GAP_CYC - 1)) ? IDLE : GAP;
                cnt_d = (cnt_q == CW'(GAP_CYC - 1)) ? '0 : cnt_q + CW'(1);
            end
        endcase
    end

    always_comb begin
        gnt_d = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
        tx_en_d = (state_d == HEAD) || (state_d == PAYLOAD);
        tx_data_d = tx_en_d & sr_d[SW-1];
        busy_d = state_d != IDLE;
        done_d = (state_q == PAYLOAD) && (state_d == GAP);
    end

    assign gnt = gnt_q;
    assign tx_data = tx_data_q;
    assign tx_en = tx_en_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_frame_tx_sched.sv
// tb_frame_tx_sched: directed checks of arbitration order, frame content and timing.
module tb_frame_tx_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   gnt;
    logic         tx_data, tx_en, busy, done;
    int           n_chk = 0, n_fail = 0, cyc = 0, t_gnt = 0, t_prev = 0, gap = 0;
    logic [3:0]   g;

    frame_tx_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_data(tx_data), .tx_en(tx_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] frm(input logic [31:0] d);
        logic [7:0] s;
        s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
        return {8'hA5, d, s};
    endfunction

    task automatic wait_gnt(input bit keep);
        g = '0;
        gap = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (gnt != 0) begin
                g = gnt;
                break;
            end
            gap++;
        end
        chk("gnt_seen", {63'd0, g != 0}, 64'd1);
        t_prev = t_gnt;
        t_gnt = cyc;
        if (!keep) req = req & ~g;
    endtask

    task automatic rx_frame(input string tag, input logic [47:0] exp);
        logic [47:0] bits;
        int en;
        en = 0;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge clk);
            bits[47-i] = tx_data;
            en += int'(tx_en);
            if (i == 1) chk({tag, "_gnt_pulse"}, {60'd0, gnt}, 64'd0);
            if (i == 47) chk({tag, "_no_early_done"}, {63'd0, done}, 64'd0);
        end
        chk({tag, "_bits"}, {16'd0, bits}, {16'd0, exp});
        chk({tag, "_en_cycles"}, 64'(en), 64'd48);
        @(negedge clk);
        chk({tag, "_done"}, {62'd0, done, tx_en}, 64'b10);
        chk({tag, "_busy_gap"}, {63'd0, busy}, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {56'd0, gnt, tx_data, tx_en, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", {56'd0, gnt, tx_data, tx_en, busy, done}, 64'd0);

        req_data[31:0] = 32'h11223344;
        req = 4'b0001;
        wait_gnt(1'b0);
        chk("single_gnt", {60'd0, g}, 64'd1);
        rx_frame("single", 48'hA5_11223344_AA);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);

        req_data[31:0] = 32'hFFFFFFFF;
        req = 4'b0001;
        wait_gnt(1'b0);
        rx_frame("csum_ff", 48'hA5_FFFFFFFF_FC);
        req_data[31:0] = 32'h80808080;
        req = 4'b0001;
        wait_gnt(1'b0);
        rx_frame("csum_80", 48'hA5_80808080_00);

        do_reset();
        req_data = 128'h13579BDF_DEADBEEF_0A0B0C0D_11111111;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1'b0);
            chk("contend_order", {60'd0, g}, 64'(4'b0001 << k));
            if (k > 0) begin
                chk("contend_spacing", 64'(t_gnt - t_prev), 64'd53);
                chk("contend_gap_low", 64'(gap + 1), 64'd5);
            end
            rx_frame("contend", frm(req_data[32*k +: 32]));
        end

        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1'b1);
            chk("fair_order", {60'd0, g}, (k % 2 == 0) ? 64'd1 : 64'd4);
            rx_frame("fair", frm(req_data[32*((k % 2) * 2) +: 32]));
        end
        req = 4'b0000;

        do_reset();
        req = 4'b0010;
        wait_gnt(1'b0);
        repeat (28) @(negedge clk);
        chk("mid_payload_en", {63'd0, tx_en}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {56'd0, gnt, tx_data, tx_en, busy, done}, 64'd0);
        @(negedge clk);
        chk("reset_no_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_regrant", {60'd0, gnt}, 64'd0);
        req = 4'b0010;
        wait_gnt(1'b0);
        chk("after_reset_gnt", {60'd0, g}, 64'd2);
        rx_frame("after_reset", frm(req_data[63:32]));

        req = 4'b0010;
        wait_gnt(1'b0);
        chk("late_first", {60'd0, g}, 64'd2);
        repeat (20) @(negedge clk);
        req[3] = 1'b1;
        wait_gnt(1'b0);
        chk("late_gnt", {60'd0, g}, 64'd8);
        chk("late_spacing", 64'(t_gnt - t_prev), 64'd53);
        rx_frame("late", frm(req_data[127:96]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
